// File: rtl/display_pkg.sv
// Shared display definitions: character codes and the 7-segment decoder.
// The game FSM uses these names to build frames, and the scanner uses them
// to decode frames.
//   char_t      : 5-bit character code
//   CH_*        : named codes (0..9, A..F, letters, dash, underscore, blank)
//   seg_decode  : char_t -> {a,b,c,d,e,f,g}, active-high, a = bit 6
package display_pkg;

  typedef logic [4:0] char_t;

  localparam char_t CH_0      = 5'd0;
  localparam char_t CH_1      = 5'd1;
  localparam char_t CH_2      = 5'd2;
  localparam char_t CH_3      = 5'd3;
  localparam char_t CH_4      = 5'd4;
  localparam char_t CH_5      = 5'd5;
  localparam char_t CH_6      = 5'd6;
  localparam char_t CH_7      = 5'd7;
  localparam char_t CH_8      = 5'd8;
  localparam char_t CH_9      = 5'd9;
  localparam char_t CH_A      = 5'd10;
  localparam char_t CH_B      = 5'd11;
  localparam char_t CH_C      = 5'd12;
  localparam char_t CH_D      = 5'd13;
  localparam char_t CH_E      = 5'd14;
  localparam char_t CH_F      = 5'd15;
  localparam char_t CH_G      = 5'd16;
  localparam char_t CH_H      = 5'd17;
  localparam char_t CH_J      = 5'd18;
  localparam char_t CH_L      = 5'd19;
  localparam char_t CH_N      = 5'd20;
  localparam char_t CH_O      = 5'd21;
  localparam char_t CH_P      = 5'd22;
  localparam char_t CH_R      = 5'd23;
  localparam char_t CH_S      = 5'd24;
  localparam char_t CH_T      = 5'd25;
  localparam char_t CH_U      = 5'd26;
  localparam char_t CH_V      = 5'd27;
  localparam char_t CH_Y      = 5'd28;
  localparam char_t CH_DASH   = 5'd29;
  localparam char_t CH_USCORE = 5'd30;
  localparam char_t CH_BLANK  = 5'd31;

  // Segment order {a,b,c,d,e,f,g}; 1 = segment lit.
  function automatic logic [6:0] seg_decode(input char_t c);
    logic [6:0] seg;
    case (c)
      CH_0:      seg = 7'h7E;
      CH_1:      seg = 7'h30;
      CH_2:      seg = 7'h6D;
      CH_3:      seg = 7'h79;
      CH_4:      seg = 7'h33;
      CH_5:      seg = 7'h5B;
      CH_6:      seg = 7'h5F;
      CH_7:      seg = 7'h70;
      CH_8:      seg = 7'h7F;
      CH_9:      seg = 7'h7B;
      CH_A:      seg = 7'h77;
      CH_B:      seg = 7'h1F;
      CH_C:      seg = 7'h4E;
      CH_D:      seg = 7'h3D;
      CH_E:      seg = 7'h4F;
      CH_F:      seg = 7'h47;
      CH_G:      seg = 7'h5E;
      CH_H:      seg = 7'h37;
      CH_J:      seg = 7'h3C;
      CH_L:      seg = 7'h0E;
      CH_N:      seg = 7'h15;
      CH_O:      seg = 7'h7E;
      CH_P:      seg = 7'h67;
      CH_R:      seg = 7'h05;
      CH_S:      seg = 7'h5B;
      CH_T:      seg = 7'h0F;
      CH_U:      seg = 7'h3E;
      CH_V:      seg = 7'h1C;
      CH_Y:      seg = 7'h3B;
      CH_DASH:   seg = 7'h01;
      CH_USCORE: seg = 7'h08;
      default:   seg = 7'h00;  // CH_BLANK and anything undefined
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bar_thermometer.sv
// Registered thermometer driver for one LED bar graph.
//   clock   : system clock
//   reset   : synchronous active-high reset (LEDs off)
//   value_i : unsigned score
//   led_o   : LED[i] lit when value_i > i, i.e. min(value_i, LED_W) LEDs on
module bar_thermometer #(
  parameter int LED_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       value_i,
  output logic [LED_W-1:0] led_o
);

  logic [LED_W-1:0] led_q, led_d;

  // NOTE: every variable driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_W; i++) begin
      led_d[i] = (int'(value_i) > i);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) led_q <= '0;
    else       led_q <= led_d;
  end

  assign led_o = led_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with a double-buffered frame, plus LED bars.
//   clock, reset : system clock, synchronous active-high reset
//   char_in      : 5-bit code per digit, digit 0 in [4:0] drives AN[0]
//   dp_in/en_in/blink_in : per-digit decimal point, enable, blink flags
//   load         : strobe capturing the frame inputs into the shadow buffer
//   bar_val      : 8-bit score per bar graph
//   AN, DDP      : registered anode selects and segments {a..g,dp}
//   LED          : registered bar graphs, bar b at LED[b*LED_W +: LED_W]
//   frame_done   : high during the last cycle of the last digit slot
module seg_scan_display
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 50,
  parameter int BLINK_FRAMES = 64,
  parameter int N_BARS       = 2,
  parameter int LED_W        = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5*N_DIGITS-1:0]     char_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       en_in,
  input  logic [N_DIGITS-1:0]       blink_in,
  input  logic                      load,
  input  logic [8*N_BARS-1:0]       bar_val,
  output logic [N_DIGITS-1:0]       AN,
  output logic [7:0]                DDP,
  output logic [LED_W*N_BARS-1:0]   LED,
  output logic                      frame_done
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

  // Idle (inactive) levels of the display pins for the chosen polarity.
  localparam logic [N_DIGITS-1:0] AN_IDLE  = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;
  localparam logic [7:0]          DDP_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef struct packed {
    char_t [N_DIGITS-1:0] chars;
    logic  [N_DIGITS-1:0] dp;
    logic  [N_DIGITS-1:0] en;
    logic  [N_DIGITS-1:0] blink;
  } frame_t;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  frame_t              shadow_q, shadow_d;
  frame_t              front_q, front_d;
  logic                pending_q, pending_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                blink_hide_q, blink_hide_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          ddp_q, ddp_d;

  logic                last_slot;
  logic                frame_end;
  logic                digit_lit;
  logic [N_DIGITS-1:0] an_raw;
  logic [7:0]          ddp_raw;

  always_comb begin
    last_slot = (slot_q == SLOT_LAST);
    frame_end = last_slot && (idx_q == IDX_LAST);

    // Scan position.
    slot_d = last_slot ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (last_slot) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Double buffer: the front frame only changes at a frame boundary, so a
    // frame is never shown half old, half new. A load on the swap cycle
    // still swaps the previous shadow and stays pending for the next frame.
    shadow_d  = shadow_q;
    front_d   = front_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      front_d   = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d.chars = char_in;
      shadow_d.dp    = dp_in;
      shadow_d.en    = en_in;
      shadow_d.blink = blink_in;
      pending_d      = 1'b1;
    end

    // Blink phase advances once per completed frame.
    blk_cnt_d    = blk_cnt_q;
    blink_hide_d = blink_hide_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d    = '0;
        blink_hide_d = ~blink_hide_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end

    // Output drive for the current slot; the first BLANK_CYC cycles of each
    // slot are dark so the previous digit does not ghost onto this anode.
    digit_lit = front_q.en[idx_q] && !(front_q.blink[idx_q] && blink_hide_q);
    an_raw    = '0;
    ddp_raw   = '0;
    if (slot_q >= SLOT_BLANK) begin
      ddp_raw = {seg_decode(front_q.chars[idx_q]), front_q.dp[idx_q]};
      if (digit_lit) an_raw[idx_q] = 1'b1;
    end
    an_d  = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
    ddp_d = (ACTIVE_LOW != 0) ? ~ddp_raw : ddp_raw;
  end

  // NOTE: the frame buffers are plain registers, not RAM, so they take a
  // reset like any other state; clearing them blanks the display and drops
  // any pending load.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      front_q      <= '0;
      pending_q    <= 1'b0;
      blk_cnt_q    <= '0;
      blink_hide_q <= 1'b0;
      an_q         <= AN_IDLE;
      ddp_q        <= DDP_IDLE;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_hide_q <= blink_hide_d;
      an_q         <= an_d;
      ddp_q        <= ddp_d;
    end
  end

  assign AN         = an_q;
  assign DDP        = ddp_q;
  assign frame_done = frame_end;

  for (genvar b = 0; b < N_BARS; b++) begin : g_bar
    bar_thermometer #(
      .LED_W (LED_W)
    ) u_bar (
      .clock   (clock),
      .reset   (reset),
      .value_i (bar_val[b*8 +: 8]),
      .led_o   (LED[b*LED_W +: LED_W])
    );
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a small scan configuration:
// 4 digits, 4 cycles per slot, 1 blank cycle, blink every 2 frames.
module tb_seg_scan_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] char_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic [3:0]  blink_in;
  logic        load;
  logic [15:0] bar_val;
  logic [3:0]  AN;
  logic [7:0]  DDP;
  logic [15:0] LED;
  logic        frame_done;

  int n_vec  = 0;
  int n_miss = 0;

  // Character sets and their active-low DDP bytes {seg[6:0], dp}, dp off.
  localparam logic [19:0] OLD_CHARS = {5'd3, 5'd2, 5'd1, 5'd0};
  localparam logic [31:0] OLD_DDP   = {8'h0D, 8'h25, 8'h9F, 8'h03};
  localparam logic [19:0] NEW_CHARS = {5'd14, 5'd15, 5'd17, 5'd29};  // E F H -
  localparam logic [31:0] NEW_DDP   = {8'h61, 8'h71, 8'h91, 8'hFD};
  // OLD chars with the decimal point lit on digit 1.
  localparam logic [31:0] DP1_DDP   = {8'h0D, 8'h25, 8'h9E, 8'h03};

  seg_scan_display #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2),
    .N_BARS       (2),
    .LED_W        (8),
    .ACTIVE_LOW   (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .char_in    (char_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .blink_in   (blink_in),
    .load       (load),
    .bar_val    (bar_val),
    .AN         (AN),
    .DDP        (DDP),
    .LED        (LED),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run until frame_done is seen, then step onto the first cycle of the
  // next frame.
  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_frame_timeout"}, 32'(n < 100), 32'd1);
    tick();
  endtask

  // Check one full frame starting just after the frame-boundary edge.
  // Sample k reflects scan state k-1: digit (k-1)/4, slot (k-1)%4.
  task automatic check_frame(input string tag, input logic [3:0] lit,
                             input logic [31:0] ddp_exp, input int load_k,
                             input logic [19:0] ld_chars);
    int         idx;
    int         slot;
    logic [3:0] exp_an;
    for (int k = 1; k <= 16; k++) begin
      if (k == load_k) begin
        char_in = ld_chars;
        load    = 1'b1;
      end
      tick();
      load = 1'b0;
      idx  = (k - 1) / 4;
      slot = (k - 1) % 4;
      exp_an = 4'hF;
      if (slot != 0 && lit[idx]) exp_an[idx] = 1'b0;
      check($sformatf("%s_an_k%0d", tag, k), 32'(AN), 32'(exp_an));
      if (slot == 0)
        check($sformatf("%s_ddp_blank_k%0d", tag, k), 32'(DDP), 32'hFF);
      else if (lit[idx])
        check($sformatf("%s_ddp_k%0d", tag, k), 32'(DDP), 32'(ddp_exp[idx*8 +: 8]));
      if (k == 14) check({tag, "_fd_low"}, 32'(frame_done), 32'd0);
      if (k == 15) check({tag, "_fd_high"}, 32'(frame_done), 32'd1);
    end
  endtask

  // Reset, then release with a load of the given frame and run through the
  // blank first frame so the loaded data becomes the front buffer.
  task automatic restart(input string tag, input logic [19:0] ch, input logic [3:0] dp,
                         input logic [3:0] en, input logic [3:0] bl);
    reset = 1'b1;
    tick();
    char_in  = ch;
    dp_in    = dp;
    en_in    = en;
    blink_in = bl;
    reset    = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    wait_frame(tag);
  endtask

  initial begin
    logic [3:0] any_lit;
    reset    = 1'b1;
    load     = 1'b0;
    char_in  = '0;
    dp_in    = '0;
    en_in    = '0;
    blink_in = '0;
    bar_val  = {8'd12, 8'd3};

    // Reset state.
    tick();
    tick();
    check("rst_an",  32'(AN),  32'hF);
    check("rst_ddp", 32'(DDP), 32'hFF);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_fd",  32'(frame_done), 32'd0);

    // Scan sequence with {3,2,1,0}.
    char_in = OLD_CHARS;
    en_in   = 4'hF;
    reset   = 1'b0;
    load    = 1'b1;
    tick();
    load = 1'b0;
    wait_frame("scan");
    check_frame("scan", 4'hF, OLD_DDP, 0, '0);

    // Tearing: load during digit 2 must not affect the frame in progress.
    check_frame("tear_old", 4'hF, OLD_DDP, 10, NEW_CHARS);
    check_frame("tear_new", 4'hF, NEW_DDP, 0, '0);

    // Blink on digit 0: visible, hidden, hidden, visible.
    restart("blink", OLD_CHARS, 4'h0, 4'hF, 4'b0001);
    check_frame("blink_f1", 4'hF,    OLD_DDP, 0, '0);
    check_frame("blink_f2", 4'b1110, OLD_DDP, 0, '0);
    check_frame("blink_f3", 4'b1110, OLD_DDP, 0, '0);
    check_frame("blink_f4", 4'hF,    OLD_DDP, 0, '0);

    // Enable mask and decimal point.
    restart("en_dp", OLD_CHARS, 4'b0010, 4'b1010, 4'b0000);
    check_frame("en_dp", 4'b1010, DP1_DDP, 0, '0);

    // Reset mid-scan with a pending load: display stays dark afterwards.
    for (int k = 0; k < 9; k++) tick();
    char_in = NEW_CHARS;
    en_in   = 4'hF;
    load    = 1'b1;
    tick();
    load  = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_an",  32'(AN),  32'hF);
    check("midrst_ddp", 32'(DDP), 32'hFF);
    check("midrst_fd",  32'(frame_done), 32'd0);
    reset = 1'b0;
    wait_frame("midrst");
    any_lit = '0;
    for (int k = 0; k < 32; k++) begin
      tick();
      any_lit = any_lit | ~AN;
    end
    check("midrst_dark", 32'(any_lit), 32'h0);

    // Bars.
    check("bar_12_3", 32'(LED), 32'hFF07);
    bar_val = {8'd0, 8'd8};
    tick();
    check("bar_0_8", 32'(LED), 32'h00FF);
    bar_val = {8'd255, 8'd7};
    tick();
    check("bar_255_7", 32'(LED), 32'hFF7F);
    bar_val = {8'd1, 8'd9};
    tick();
    check("bar_1_9", 32'(LED), 32'h01FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed 7-segment scanner plus LED bar-graph driver for the game board. It replaces the fixed 8-digit, fixed-text display path with a generic frame-buffered scanner. Game logic supplies a frame of character codes with per-digit enable, decimal point and blink flags; this block double-buffers the frame, scans digits with an anti-ghosting blank interval, and drives thermometer bars for player scores.

Parameters:
N_DIGITS, 8, number of multiplexed digits (2..16)
REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYC+2)
BLANK_CYC, 50, cycles at the start of each slot with all anodes off
BLINK_FRAMES, 64, full scan frames per blink half-period
N_BARS, 2, number of LED bar graphs
LED_W, 8, LEDs per bar
ACTIVE_LOW, 1, 1: AN/DDP asserted low; 0: asserted high

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
char_in  in  5*N_DIGITS  character code per digit; digit 0 is bits [4:0] and drives AN[0]
dp_in  in  N_DIGITS  decimal point per digit
en_in  in  N_DIGITS  digit enable; 0 = digit dark
blink_in  in  N_DIGITS  digit blinks when 1
load  in  1  one-cycle strobe: capture char_in/dp_in/en_in/blink_in into the shadow buffer
bar_val  in  8*N_BARS  unsigned score per bar
AN  out  N_DIGITS  anode selects
DDP  out  8  segments {a,b,c,d,e,f,g,dp}, a = DDP[7]
LED  out  LED_W*N_BARS  bar b occupies LED[b*LED_W +: LED_W]
frame_done  out  1  one-cycle pulse at the last cycle of digit N_DIGITS-1

Behaviour:
- Reset is synchronous and active-high; all state is clocked on clock only. No derived clocks, only enables.
- Reset values: AN and DDP all inactive (all-1 when ACTIVE_LOW), LED 0, frame_done 0, slot counter 0, digit index 0, blink phase visible, blink counter 0, shadow and front buffers all en=0 (blank), pending flag 0.
- Slot counter counts 0..REFRESH_DIV-1 and wraps. At each wrap, digit index increments and wraps from N_DIGITS-1 to 0.
- Blank interval: while slot counter < BLANK_CYC, AN is all inactive and DDP is inactive.
- Otherwise AN asserts only bit[idx], and only if front.en[idx]=1 and the digit is not blink-suppressed.
- Blink suppression: blink[idx]=1 and blink phase is hidden.
- DDP[7:1] = decode(front.char[idx]); DDP[0] = front.dp[idx]. Polarity is applied by ACTIVE_LOW.
- AN, DDP and LED are registered outputs: one cycle of latency from the counter/index state.
- Double buffer: load copies inputs to shadow and sets pending. At the cycle the index wraps to 0 with pending=1, shadow copies to front and pending clears. This guarantees no mid-frame tearing.
- load coinciding with the swap cycle: the swap uses the old shadow, the new data goes into shadow, and pending stays 1.
- Multiple loads within a frame: the last one wins.
- frame_done asserts in the cycle where idx=N_DIGITS-1 and slot=REFRESH_DIV-1.
- Blink counter increments on frame_done. At BLINK_FRAMES-1 it wraps and toggles the blink phase.
- Decode codes 0..9 as digits, 10..15 as A,b,C,d,E,F. Codes 16..30 are letters G,H,J,L,n,O,P,r,S,t,U,V,Y,-,_ . Code 31 is blank. Any undefined code is blank.
- Bars: the thermometer count is min(bar_val, LED_W); LEDs [count-1:0] are on. The LED output is registered each cycle, independent of the scan.
- Reset asserted mid-scan returns to the reset state on the next edge, and a pending load is discarded.

Decomposition:
- The shared package display_pkg holds the 5-bit char_t, named code constants (CH_0..CH_9, CH_A.., CH_BLANK=31), and the function seg_decode(char_t) returning 7 bits active-high.
- The game FSM uses the same package to build frames.
- One natural sub-module, bar_thermometer (parameter LED_W, 8-bit value in, LED_W out, registered), instantiated N_BARS times.

Test Plan:
Config for all scenarios: N_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, ACTIVE_LOW=1.
1. Reset. Check that AN=4'b1111, DDP=8'hFF and LED=0 on the cycle after reset. Load {3,2,1,0}, en=4'hF, then release reset. Check the expected AN sequence 1110,1101,1011,0111 per slot, with 1111 in each slot's first active cycle. During digit 0, DDP[7:1] must equal ~seg_decode(0)=7'b0000001.
2. Tearing. Assert load with new chars mid-frame, while idx=2. Digits 2 and 3 must still show the old values. The new values must appear starting at the next idx=0 slot.
3. Blink. Set blink_in=4'b0001 with all digits enabled. AN[0] must never assert for 2 frames, then assert for 2 frames, and so on. AN[3:1] must remain unaffected.
4. Enable and DP. Set en_in=4'b1010 and dp_in=4'b0010. AN[0] and AN[2] must stay 1. During the digit-1 slot, DDP[0] must be 0.
5. Bars. Drive bar_val={8'd12, 8'd3}. Check LED[7:0]=8'b00000111 and LED[15:8]=8'hFF (saturated). Change bar_val to {0,8} and check LED={8'h00, 8'hFF} after 1 cycle.
6. Reset mid-scan. Assert reset at idx=2 with a load pending. AN must go to 1111 on the next edge. After release, the display must stay blank, because the pending load was discarded.
